// File: rtl/corefifo_rd_ctrl_pkg.sv
// rtl/corefifo_rd_ctrl_pkg.sv - shared widths, buffer state type and Gray helper for the CoreFIFO read side
package corefifo_rd_ctrl_pkg;

    // Widest pointer the Gray helper handles; callers zero-extend and truncate.
    localparam int GRAY_MAXW = 32;

    // Output buffer occupancy; the encoding doubles as the entry count.
    typedef enum logic [1:0] {
        OB_EMPTY = 2'd0,
        OB_ONE   = 2'd1,
        OB_TWO   = 2'd2
    } ob_state_e;

    // Pointer width: one extra MSB distinguishes full from empty on wrap.
    function automatic int ptr_width(input int addr_width);
        return addr_width + 1;
    endfunction

    // Level width: must hold depth + 2 (RAM contents plus in-flight plus buffer).
    function automatic int lvl_width(input int addr_width);
        return addr_width + 2;
    endfunction

    // Zero-extension is harmless: the top Gray bit is then just the binary MSB.
    function automatic logic [GRAY_MAXW-1:0] bin2gray(input logic [GRAY_MAXW-1:0] bin);
        return bin ^ (bin >> 1);
    endfunction

endpackage

// File: rtl/corefifo_grayToBinConv.sv
// rtl/corefifo_grayToBinConv.sv - combinational Gray-to-binary pointer converter
//
// Ports:
//   gray  in   WIDTH  Gray-coded value
//   bin   out  WIDTH  binary equivalent (combinational)
module corefifo_grayToBinConv #(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] gray,
    output logic [WIDTH-1:0] bin
);

    // Each binary bit is the XOR of all Gray bits at or above it.
    always_comb begin
        bin = '0;
        for (int i = 0; i < WIDTH; i++) begin
            bin[i] = ^(gray >> i);
        end
    end

endmodule

// File: rtl/corefifo_rd_ctrl.sv
// rtl/corefifo_rd_ctrl.sv - CoreFIFO read-domain controller with 2-entry FWFT output buffer
//
// Ports:
//   rclk            in   1            read clock
//   rreset_n        in   1            synchronous active-low reset
//   wptr_gray_sync  in   ADDRWIDTH+1  synchronised Gray write pointer
//   ram_rdata       in   DWIDTH       RAM data, valid the cycle after ram_ren
//   rd_ready        in   1            consumer accepts rd_data
//   ram_ren         out  1            RAM read enable
//   ram_raddr       out  ADDRWIDTH    RAM read address
//   rptr_gray       out  ADDRWIDTH+1  registered Gray read pointer
//   rd_valid        out  1            rd_data holds the head entry
//   rd_data         out  DWIDTH       buffer head
//   empty           out  1            !rd_valid
//   almost_empty    out  1            rd_level <= AE_THRESH, registered
//   rd_level        out  ADDRWIDTH+2  entries held in RAM, in flight and buffer
module corefifo_rd_ctrl
    import corefifo_rd_ctrl_pkg::*;
#(
    parameter int ADDRWIDTH = 3,
    parameter int DWIDTH    = 18,
    parameter int AE_THRESH = 1
) (
    input  logic                          rclk,
    input  logic                          rreset_n,
    input  logic [ptr_width(ADDRWIDTH)-1:0] wptr_gray_sync,
    input  logic [DWIDTH-1:0]             ram_rdata,
    input  logic                          rd_ready,
    output logic                          ram_ren,
    output logic [ADDRWIDTH-1:0]          ram_raddr,
    output logic [ptr_width(ADDRWIDTH)-1:0] rptr_gray,
    output logic                          rd_valid,
    output logic [DWIDTH-1:0]             rd_data,
    output logic                          empty,
    output logic                          almost_empty,
    output logic [lvl_width(ADDRWIDTH)-1:0] rd_level
);

    localparam int PTRW = ptr_width(ADDRWIDTH);
    localparam int LVLW = lvl_width(ADDRWIDTH);

    logic [PTRW-1:0]   wbin_q, wbin_d;
    logic [PTRW-1:0]   rbin_q, rbin_d;
    logic [PTRW-1:0]   rptr_gray_q, rptr_gray_d;
    logic              inflight_q, inflight_d;
    ob_state_e         ob_state_q, ob_state_d;
    logic [DWIDTH-1:0] head_q, head_d;
    logic [DWIDTH-1:0] skid_q, skid_d;
    logic [LVLW-1:0]   rd_level_q, rd_level_d;
    logic              ae_q, ae_d;

    logic              pop;
    logic              ram_empty;
    logic [1:0]        ob_cnt;
    logic [2:0]        ob_after;
    logic [PTRW-1:0]   ptr_diff;

    corefifo_grayToBinConv #(
        .WIDTH (PTRW)
    ) u_wptr_conv (
        .gray (wptr_gray_sync),
        .bin  (wbin_d)
    );

    assign rd_valid     = (ob_state_q != OB_EMPTY);
    assign empty        = !rd_valid;
    assign rd_data      = head_q;
    assign rptr_gray    = rptr_gray_q;
    assign rd_level     = rd_level_q;
    assign almost_empty = ae_q;
    assign ram_raddr    = rbin_q[ADDRWIDTH-1:0];
    assign pop          = rd_valid & rd_ready;
    assign ob_cnt       = ob_state_q;
    assign ram_empty    = (wbin_q == rbin_q);

    // Issue only if the word can be absorbed: buffer count after this cycle's
    // return and pop must leave room for the word arriving next cycle.
    always_comb begin
        ob_after = {1'b0, ob_cnt} + {2'b00, inflight_q} - {2'b00, pop};
        ram_ren  = !ram_empty && (ob_after < 3'd2);
    end

    always_comb begin
        ob_state_d = ob_state_q;
        case (ob_state_q)
            OB_EMPTY: if (inflight_q) ob_state_d = OB_ONE;
            OB_ONE: begin
                if (inflight_q && !pop)      ob_state_d = OB_TWO;
                else if (!inflight_q && pop) ob_state_d = OB_EMPTY;
            end
            OB_TWO:   if (pop && !inflight_q) ob_state_d = OB_ONE;
            default:  ob_state_d = OB_EMPTY;
        endcase
    end

    // Pop shifts skid forward first; a returning word then goes to the head if
    // the head is (or is becoming) free, otherwise into the skid slot.
    always_comb begin
        head_d = head_q;
        skid_d = skid_q;
        if (pop && ob_state_q == OB_TWO) begin
            head_d = skid_q;
        end
        if (inflight_q) begin
            if (ob_state_q == OB_EMPTY || (ob_state_q == OB_ONE && pop)) begin
                head_d = ram_rdata;
            end else begin
                skid_d = ram_rdata;
            end
        end
    end

    always_comb begin
        rbin_d      = rbin_q + {{(PTRW-1){1'b0}}, ram_ren};
        inflight_d  = ram_ren;
        rptr_gray_d = PTRW'(bin2gray(GRAY_MAXW'(rbin_d)));
        ptr_diff    = wbin_d - rbin_d;
        rd_level_d  = LVLW'(ptr_diff) + LVLW'(inflight_d) + LVLW'(ob_state_d);
        ae_d        = (rd_level_d <= LVLW'(AE_THRESH));
    end

    always_ff @(posedge rclk) begin
        if (!rreset_n) begin
            wbin_q      <= '0;
            rbin_q      <= '0;
            rptr_gray_q <= '0;
            inflight_q  <= 1'b0;
            ob_state_q  <= OB_EMPTY;
            head_q      <= '0;
            skid_q      <= '0;
            rd_level_q  <= '0;
            ae_q        <= 1'b1;
        end else begin
            wbin_q      <= wbin_d;
            rbin_q      <= rbin_d;
            rptr_gray_q <= rptr_gray_d;
            inflight_q  <= inflight_d;
            ob_state_q  <= ob_state_d;
            head_q      <= head_d;
            skid_q      <= skid_d;
            rd_level_q  <= rd_level_d;
            ae_q        <= ae_d;
        end
    end

endmodule

// File: tb/tb_corefifo_rd_ctrl.sv
// tb/tb_corefifo_rd_ctrl.sv - self-checking bench for corefifo_rd_ctrl with RAM model and scoreboard
module tb_corefifo_rd_ctrl;

    logic        clk = 1'b0;
    logic        rreset_n;
    logic [3:0]  wptr_gray_sync;
    logic [17:0] ram_rdata;
    logic        rd_ready;
    logic        ram_ren;
    logic [2:0]  ram_raddr;
    logic [3:0]  rptr_gray;
    logic        rd_valid;
    logic [17:0] rd_data;
    logic        empty;
    logic        almost_empty;
    logic [4:0]  rd_level;

    corefifo_rd_ctrl #(
        .ADDRWIDTH (3),
        .DWIDTH    (18),
        .AE_THRESH (1)
    ) dut (
        .rclk           (clk),
        .rreset_n       (rreset_n),
        .wptr_gray_sync (wptr_gray_sync),
        .ram_rdata      (ram_rdata),
        .rd_ready       (rd_ready),
        .ram_ren        (ram_ren),
        .ram_raddr      (ram_raddr),
        .rptr_gray      (rptr_gray),
        .rd_valid       (rd_valid),
        .rd_data        (rd_data),
        .empty          (empty),
        .almost_empty   (almost_empty),
        .rd_level       (rd_level)
    );

    always #5 clk = ~clk;

    logic [17:0] mem [8];
    always @(posedge clk) begin
        if (ram_ren) ram_rdata <= mem[ram_raddr];
    end

    int          total = 0;
    int          bad   = 0;
    int          ren_cnt, pop_cnt, gaps, p0;
    logic [3:0]  wbin, exp_rbin, prev_gray;
    logic [17:0] next_data;
    logic [17:0] sb [$];
    bit          track_gaps, seen_first;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    function automatic logic [3:0] g(input logic [3:0] b);
        return b ^ (b >> 1);
    endfunction

    function automatic logic [3:0] g2b(input logic [3:0] gr);
        logic [3:0] b;
        for (int i = 0; i < 4; i++) b[i] = ^(gr >> i);
        return b;
    endfunction

    // One clock: drive write side and rd_ready, observe issue/pop, advance to edge+1.
    task automatic cycle(input bit do_wr, input bit rdy);
        logic [3:0] rb;
        rd_ready = rdy;
        if (do_wr) begin
            rb = g2b(rptr_gray);
            if (4'(wbin - rb) < 4'd8) begin
                mem[wbin[2:0]] = next_data;
                sb.push_back(next_data);
                next_data = next_data + 18'h0135;
                wbin = wbin + 4'd1;
                wptr_gray_sync = g(wbin);
            end
        end
        #1;
        if (ram_ren) begin
            chk("raddr", 32'(ram_raddr), 32'(exp_rbin[2:0]));
            exp_rbin = exp_rbin + 4'd1;
            ren_cnt++;
        end
        if (track_gaps) begin
            if (rd_valid) seen_first = 1'b1;
            else if (seen_first && sb.size() != 0) gaps++;
        end
        if (rd_valid && rdy) begin
            chk("sb_nonempty", 32'(sb.size() != 0), 32'd1);
            if (sb.size() != 0) chk("data", 32'(rd_data), 32'(sb.pop_front()));
            pop_cnt++;
        end
        @(posedge clk);
        #1;
        chk("gray_step", 32'($countones(rptr_gray ^ prev_gray) <= 1), 32'd1);
        chk("rptr_gray", 32'(rptr_gray), 32'(g(exp_rbin)));
        prev_gray = rptr_gray;
    endtask

    task automatic do_reset();
        rreset_n = 1'b0;
        rd_ready = 1'b0;
        wptr_gray_sync = 4'd0;
        @(posedge clk);
        @(posedge clk);
        #1;
        wbin = 4'd0;
        exp_rbin = 4'd0;
        prev_gray = 4'd0;
        sb.delete();
        rreset_n = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 8; i++) mem[i] = 18'd0;
        ram_rdata = 18'd0;
        next_data = 18'h00100;
        track_gaps = 1'b0;
        seen_first = 1'b0;
        ren_cnt = 0;
        pop_cnt = 0;
        gaps = 0;

        // Reset with a non-zero write pointer present
        rreset_n = 1'b0;
        rd_ready = 1'b0;
        wptr_gray_sync = 4'b0110;
        @(posedge clk);
        @(posedge clk);
        #1;
        chk("rst_valid", 32'(rd_valid), 32'd0);
        chk("rst_empty", 32'(empty), 32'd1);
        chk("rst_ae", 32'(almost_empty), 32'd1);
        chk("rst_ren", 32'(ram_ren), 32'd0);
        chk("rst_rptr", 32'(rptr_gray), 32'd0);
        chk("rst_level", 32'(rd_level), 32'd0);
        chk("rst_data", 32'(rd_data), 32'd0);
        rreset_n = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1;
        chk("rst_release_level", 32'(rd_level), 32'd4);
        do_reset();

        // Single word, consumer stalled
        ren_cnt = 0;
        cycle(1'b1, 1'b0);
        chk("sw_ren", 32'(ram_ren), 32'd1);
        chk("sw_raddr", 32'(ram_raddr), 32'd0);
        chk("sw_valid_early", 32'(rd_valid), 32'd0);
        cycle(1'b0, 1'b0);
        chk("sw_valid_k1", 32'(rd_valid), 32'd0);
        cycle(1'b0, 1'b0);
        chk("sw_valid_k2", 32'(rd_valid), 32'd1);
        chk("sw_empty", 32'(empty), 32'd0);
        chk("sw_data", 32'(rd_data), 32'(sb[0]));
        chk("sw_level", 32'(rd_level), 32'd1);
        chk("sw_ae", 32'(almost_empty), 32'd1);
        chk("sw_rptr", 32'(rptr_gray), 32'b0001);
        cycle(1'b0, 1'b0);
        cycle(1'b0, 1'b0);
        chk("sw_ren_cnt", 32'(ren_cnt), 32'd1);
        cycle(1'b0, 1'b1);
        cycle(1'b0, 1'b0);
        chk("sw_drained", 32'(rd_valid), 32'd0);
        chk("sw_empty_after", 32'(empty), 32'd1);

        // Stall with 5 words, then drain
        ren_cnt = 0;
        for (int i = 0; i < 5; i++) cycle(1'b1, 1'b0);
        for (int i = 0; i < 4; i++) cycle(1'b0, 1'b0);
        chk("stall_ren_cnt", 32'(ren_cnt), 32'd2);
        chk("stall_ren_now", 32'(ram_ren), 32'd0);
        chk("stall_level", 32'(rd_level), 32'd5);
        chk("stall_ae", 32'(almost_empty), 32'd0);
        chk("stall_valid", 32'(rd_valid), 32'd1);
        p0 = pop_cnt;
        for (int i = 0; i < 5; i++) cycle(1'b0, 1'b1);
        chk("drain_pops", 32'(pop_cnt - p0), 32'd5);
        chk("drain_valid_end", 32'(rd_valid), 32'd0);
        chk("drain_ren_cnt", 32'(ren_cnt), 32'd5);

        // Return and pop in the same cycle with one buffered entry
        ren_cnt = 0;
        cycle(1'b1, 1'b0);
        cycle(1'b1, 1'b0);
        cycle(1'b0, 1'b0);
        chk("sim_valid", 32'(rd_valid), 32'd1);
        cycle(1'b0, 1'b1);
        chk("sim_valid_after", 32'(rd_valid), 32'd1);
        chk("sim_level", 32'(rd_level), 32'd1);
        chk("sim_head", 32'(rd_data), 32'(sb[0]));
        cycle(1'b0, 1'b1);
        cycle(1'b0, 1'b0);
        chk("sim_valid_end", 32'(rd_valid), 32'd0);
        chk("sim_sb_empty", 32'(sb.size()), 32'd0);
        chk("sim_ren_cnt", 32'(ren_cnt), 32'd2);

        // Wrap-around streaming from a fresh reset
        do_reset();
        ren_cnt = 0;
        p0 = pop_cnt;
        gaps = 0;
        seen_first = 1'b0;
        track_gaps = 1'b1;
        for (int i = 0; i < 20; i++) cycle(1'b1, 1'b1);
        for (int i = 0; i < 40 && sb.size() != 0; i++) cycle(1'b0, 1'b1);
        cycle(1'b0, 1'b1);
        track_gaps = 1'b0;
        chk("wrap_drained", 32'(sb.size()), 32'd0);
        chk("wrap_pops", 32'(pop_cnt - p0), 32'd20);
        chk("wrap_ren_cnt", 32'(ren_cnt), 32'd20);
        chk("wrap_gaps", 32'(gaps), 32'd0);
        chk("wrap_rptr", 32'(rptr_gray), 32'b0110);
        chk("wrap_valid_end", 32'(rd_valid), 32'd0);

        // Reset while the buffer is full
        for (int i = 0; i < 4; i++) cycle(1'b1, 1'b0);
        for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0);
        chk("mid_valid", 32'(rd_valid), 32'd1);
        chk("mid_level", 32'(rd_level), 32'd4);
        rreset_n = 1'b0;
        wptr_gray_sync = 4'd0;
        @(posedge clk);
        #1;
        chk("mid_rst_valid", 32'(rd_valid), 32'd0);
        chk("mid_rst_empty", 32'(empty), 32'd1);
        chk("mid_rst_ae", 32'(almost_empty), 32'd1);
        chk("mid_rst_ren", 32'(ram_ren), 32'd0);
        chk("mid_rst_data", 32'(rd_data), 32'd0);
        chk("mid_rst_rptr", 32'(rptr_gray), 32'd0);
        chk("mid_rst_level", 32'(rd_level), 32'd0);
        @(posedge clk);
        #1;
        chk("mid_rst_ren2", 32'(ram_ren), 32'd0);
        chk("mid_rst_valid2", 32'(rd_valid), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/corefifo_rd_ctrl.md
# corefifo_rd_ctrl

Read-side controller for the async CoreFIFO, in the read clock domain. It takes the write pointer (Gray-coded, already synchronised into this domain) and converts it to binary. It then schedules reads from the dual-port RAM (1-cycle read latency) into a 2-entry first-word-fall-through output buffer with a valid/ready handshake. It publishes the Gray-coded read pointer back to the write domain and generates the empty, almost-empty and level status.

## Interface
- ADDRWIDTH, 3, RAM address width; depth = 2^ADDRWIDTH; pointers are ADDRWIDTH+1 bits
- DWIDTH, 18, data width
- AE_THRESH, 1, almost_empty asserted when rd_level <= AE_THRESH
- rclk  in  1  read clock; single clock domain
- rreset_n  in  1  synchronous, active-low reset
- wptr_gray_sync  in  ADDRWIDTH+1  write pointer, Gray, already 2-flop synchronised
- ram_rdata  in  DWIDTH  RAM read data, valid the cycle after ram_ren
- rd_ready  in  1  consumer accepts rd_data
- ram_ren  out  1  RAM read enable
- ram_raddr  out  ADDRWIDTH  RAM read address = rbin[ADDRWIDTH-1:0]
- rptr_gray  out  ADDRWIDTH+1  registered Gray read pointer, to write-domain sync
- rd_valid  out  1  rd_data holds the head entry
- rd_data  out  DWIDTH  head of output buffer, registered
- empty  out  1  equals !rd_valid
- almost_empty  out  1  registered level flag
- rd_level  out  ADDRWIDTH+2  total entries held (RAM + in-flight + buffer), registered

## Operation
- wbin_q: registered binary of wptr_gray_sync (converter output registered every cycle).
- rbin: binary read pointer, ADDRWIDTH+1 bits; increments by 1 (mod 2^(ADDRWIDTH+1)) on every cycle ram_ren=1.
- ram_empty = (wbin_q == rbin), full pointer width compare, so wrap is handled by the MSB.
- inflight: 1 in the cycle after ram_ren, else 0. ob_cnt: buffer entries, 0..2.
- pop = rd_valid & rd_ready.
- ram_ren = !ram_empty & (ob_cnt + inflight - pop < 2). Combinational from registers and rd_ready.
- Data return: when inflight=1, ram_rdata is written to the buffer.
  - If the buffer is empty, or holds 1 entry that is popped this cycle, it goes to the head.
  - Otherwise it goes to the skid slot.
- On pop, skid moves to head when present.
- ob_cnt(next) = ob_cnt + inflight - pop.
- rd_ready while rd_valid=0 is ignored; there is no underflow path.
- rptr_gray <= rbin_next ^ (rbin_next >> 1), registered. A RAM slot is released at read issue, which is safe because the data is held in the buffer.
- rd_level <= (wbin_q - rbin) mod 2^(ADDRWIDTH+1) + inflight + ob_cnt, using next-state values. Maximum is depth + 2.
- almost_empty <= (rd_level_next <= AE_THRESH).
- Buffer is effectively a 3-state FSM on ob_cnt: EMPTY(0) -> ONE on data return; ONE -> TWO on return without pop; TWO -> ONE on pop without return; ONE -> EMPTY on pop without return. Return and pop together keep the state.

## Timing
- Reset (rreset_n=0 at a rclk edge):
  - rbin, wbin_q, rptr_gray, ob_cnt, inflight, rd_level = 0.
  - rd_valid=0, empty=1, almost_empty=1, ram_ren=0, rd_data=0.
- Reset mid-operation discards buffer and in-flight data. The write side is reset together with this block.
- Latency, empty FIFO: write pointer sampled at edge k -> wbin_q at k -> ram_ren high in cycle k+1 -> ram_rdata in cycle k+2 -> captured at edge k+2 -> rd_valid=1 from cycle k+2 (3 edges after the pointer is seen).
- Throughput: 1 word/cycle sustained while ram_empty=0 and rd_ready=1. No bubbles after fill.
- rd_ready=0: at most 2 further reads are issued (buffer full), then ram_ren=0 until a pop.
- rptr_gray changes at most one bit per cycle.
- Status flags lag the pointers by 1 register stage.

## Structure
- Shared package/constants: ADDRWIDTH-derived widths (PTRW = ADDRWIDTH+1, LVLW = ADDRWIDTH+2) and the bin-to-Gray function.
- One sub-module: reuse corefifo_grayToBinConv for wptr_gray_sync -> binary, output registered here.
- Output buffer and issue logic stay inline.

## Test plan
All scenarios use ADDRWIDTH=3, AE_THRESH=1.
- Reset: hold rreset_n=0 for 2 cycles with wptr_gray_sync=4'b0110 -> rd_valid=0, empty=1, ram_ren=0, rptr_gray=0, rd_level=0. After release, rd_level=4 within 2 cycles.
- Single word: wptr_gray_sync 0000->0001 at edge k, rd_ready=0 -> one ram_ren in cycle k+1 with raddr=0; rd_valid=1 at k+2; rd_level=1; almost_empty=1; rptr_gray=0001.
- Stall then drain: 5 words written, rd_ready=0 -> exactly 2 ram_ren, ob_cnt=2, rd_level=5. Then rd_ready=1 -> 5 words out in order on 5 consecutive cycles, then rd_valid=0.
- Wrap-around: 20 words streamed at rd_ready=1 -> rbin wraps 15->0, raddr sequence 0..7,0..7,0..3, data in order, no gaps after the first word.
- Simultaneous events: with ob_cnt=1, inflight=1 and pop in the same cycle -> returned word lands in head, ob_cnt stays 1, no data lost or duplicated.
- Reset mid-stream: assert rreset_n=0 while rd_valid=1, ob_cnt=2 -> next cycle all outputs at reset values, no residual ram_ren.
